pool2x2_stream: RTL and testbench

Parametrised 2x2/stride-2 pooling engine for the CNN feature-map datapath. It replaces the externally sequenced pooler with a self-counting streaming block. Each input beat carries `LANES` signed channels of one pixel, and one output beat is produced per 2x2 window. The mode is selectable between max and average, with valid/ready handshakes on both sides and an internal line buffer holding half-row partial results.

---
 rtl/pool_pkg.sv | 40 ++++
 rtl/pool_linebuf.sv | 37 +++
 rtl/pool2x2_stream.sv | 227 ++++++++++++++++++++++
 tb/tb_pool2x2_stream.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the 2x2/stride-2 pooling engine:
//   - pool_state_e : controller states (idle / streaming / draining output)
//   - POOL_MODE_*  : encoding of the cfg_mode input
//   - pool_combine : per-lane combine step (signed max, or sum for average)
// pool_combine works on a wide signed accumulator so the same function
// serves the horizontal (DW -> DW+1) and vertical (DW+1 -> DW+2) stages.
// Callers sign-extend into it and size-cast the result back down.
// ---------------------------------------------------------------------------
package pool_pkg;

    typedef enum logic [1:0] {
        POOL_IDLE  = 2'd0,
        POOL_RUN   = 2'd1,
        POOL_DRAIN = 2'd2
    } pool_state_e;

    localparam logic POOL_MODE_MAX = 1'b0;
    localparam logic POOL_MODE_AVG = 1'b1;

    // Accumulator width used by pool_combine; comfortably wider than any
    // DW+2 intermediate this engine produces.
    localparam int POOL_ACC_W = 64;

    function automatic logic signed [POOL_ACC_W-1:0] pool_combine(
        input logic                         mode,
        input logic signed [POOL_ACC_W-1:0] a,
        input logic signed [POOL_ACC_W-1:0] b
    );
        logic signed [POOL_ACC_W-1:0] r;
        if (mode == POOL_MODE_AVG) begin
            r = a + b;
        end else begin
            r = (a > b) ? a : b;
        end
        return r;
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// ---------------------------------------------------------------------------
// pool_linebuf
// Single-port RAM with a registered (synchronous) read, holding one
// horizontally-combined half-row of partial results.
// A cycle either writes (we=1) or reads (we=0); read data appears on rdata
// the cycle after the address is presented. No reset on the array or on
// rdata so the block maps directly onto the SRAM wrapper.
// Ports:
//   clk   : clock
//   we    : write enable (otherwise the cycle is a read)
//   addr  : entry address, 0..DEPTH-1
//   wdata : write data, W bits
//   rdata : registered read data, W bits
// ---------------------------------------------------------------------------
module pool_linebuf #(
    parameter int DEPTH = 512,
    parameter int W     = 34,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/pool2x2_stream.sv
// ---------------------------------------------------------------------------
// pool2x2_stream
// Self-counting streaming 2x2/stride-2 pooling engine (max or floor-average)
// over LANES signed DW-bit channels packed per beat, pixels in raster order.
//
// Dataflow per lane:
//   even column          : beat parked in hreg
//   odd column           : h = combine(hreg, beat)              (DW+1 bits)
//   even row, odd column : h written to the line buffer at col>>1
//   odd row, even column : line buffer read at col>>1 (lands in rdata = vreg)
//   odd row, odd column  : result = combine(vreg, h), averaged if mode 1,
//                          loaded into the output register
// A trailing odd column / odd row is accepted and discarded.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : one-cycle pulse, latches cfg_* (ignored when busy)
//   cfg_width, cfg_height : frame size in pixels (width 2..MAX_W, height >= 2)
//   cfg_mode              : 0 = max, 1 = average
//   in_valid/in_ready/in_data    : input pixel stream
//   out_valid/out_ready/out_data : pooled pixel stream
//   busy                  : frame in progress
//   done                  : one-cycle pulse once the last output has left
// ---------------------------------------------------------------------------
module pool2x2_stream
    import pool_pkg::*;
#(
    parameter int DW    = 16,
    parameter int LANES = 2,
    parameter int MAX_W = 1024,
    parameter int CW    = $clog2(MAX_W + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CW-1:0]       cfg_width,
    input  logic [CW-1:0]       cfg_height,
    input  logic                cfg_mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] out_data,
    output logic                busy,
    output logic                done
);

    localparam int DEPTH = MAX_W / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LBW   = LANES * (DW + 1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    pool_state_e         state_q;
    logic [CW-1:0]       width_q;
    logic [CW-1:0]       height_q;
    logic                mode_q;
    logic [CW-1:0]       col_q, col_d;
    logic [CW-1:0]       row_q, row_d;
    logic [LANES*DW-1:0] hreg_q;
    logic                out_valid_q;
    logic [LANES*DW-1:0] out_data_q;
    logic                done_q;

    // -----------------------------------------------------------------------
    // Beat classification
    // -----------------------------------------------------------------------
    logic           accept;
    logic           lastCol, lastRow;
    logic           keepRow;
    logic           colOdd, rowOdd;
    logic           lbWe;
    logic [AW-1:0]  lbAddr;
    logic           resLoad;

    logic [LBW-1:0]      hPacked;
    logic [LBW-1:0]      lbRdata;
    logic [LANES*DW-1:0] resPacked;

    assign in_ready = (state_q == POOL_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign lastCol = (col_q == width_q - CW'(1));
    assign lastRow = (row_q == height_q - CW'(1));
    assign colOdd  = col_q[0];
    assign rowOdd  = row_q[0];

    // The trailing row of an odd-height frame is swallowed. The trailing
    // column of an odd-width frame is always an even column, so it only ever
    // touches hreg (and issues a harmless read) and never produces output.
    assign keepRow = !(height_q[0] && lastRow);

    assign lbWe    = accept && keepRow && !rowOdd && colOdd;
    assign resLoad = accept && keepRow &&  rowOdd && colOdd;

    // Both pixels of a horizontal pair share col>>1, so the address stays put
    // between the even-column read and the odd-column use of its data; the
    // buffer's registered output therefore serves directly as vreg.
    assign lbAddr = col_q[AW:1];

    // Raster position advance for an accepted beat.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (lastCol) begin
                col_d = '0;
                if (!lastRow) begin
                    row_d = row_q + CW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-lane arithmetic
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DW-1:0] hregLane;
        logic signed [DW-1:0] inLane;
        logic signed [DW:0]   hLane;
        logic signed [DW:0]   vLane;
        logic signed [DW+1:0] vSum;
        logic signed [DW-1:0] resLane;

        assign hregLane = hreg_q[k*DW +: DW];
        assign inLane   = in_data[k*DW +: DW];
        assign vLane    = lbRdata[k*(DW+1) +: DW+1];

        assign hLane = (DW+1)'(pool_combine(mode_q, POOL_ACC_W'(hregLane),
                                            POOL_ACC_W'(inLane)));
        assign vSum  = (DW+2)'(pool_combine(mode_q, POOL_ACC_W'(vLane),
                                            POOL_ACC_W'(hLane)));

        // Arithmetic shift floors toward -inf; the DW+2 sum of four DW
        // values cannot overflow, and its quarter always fits back in DW.
        assign resLane = (mode_q == POOL_MODE_AVG) ? DW'(vSum >>> 2)
                                                   : DW'(vSum);

        assign hPacked[k*(DW+1) +: DW+1] = hLane;
        assign resPacked[k*DW +: DW]     = resLane;
    end

    pool_linebuf #(
        .DEPTH (DEPTH),
        .W     (LBW)
    ) u_linebuf (
        .clk   (clk),
        .we    (lbWe),
        .addr  (lbAddr),
        .wdata (hPacked),
        .rdata (lbRdata)
    );

    // -----------------------------------------------------------------------
    // Controller, datapath registers and output handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= POOL_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            mode_q      <= POOL_MODE_MAX;
            col_q       <= '0;
            row_q       <= '0;
            hreg_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // A new result can only be accepted when the output slot is free
            // or emptying this cycle, so the load simply overrides the clear.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (resLoad) begin
                out_valid_q <= 1'b1;
                out_data_q  <= resPacked;
            end

            if (accept && !colOdd) begin
                hreg_q <= in_data;
            end

            case (state_q)
                POOL_IDLE: begin
                    if (start) begin
                        width_q  <= cfg_width;
                        height_q <= cfg_height;
                        mode_q   <= cfg_mode;
                        col_q    <= '0;
                        row_q    <= '0;
                        state_q  <= POOL_RUN;
                    end
                end
                POOL_RUN: begin
                    col_q <= col_d;
                    row_q <= row_d;
                    if (accept && lastCol && lastRow) begin
                        state_q <= POOL_DRAIN;
                    end
                end
                POOL_DRAIN: begin
                    if (!out_valid_q || out_ready) begin
                        state_q <= POOL_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= POOL_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != POOL_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
// ---------------------------------------------------------------------------
// tb_pool2x2_stream
// Directed bench for pool2x2_stream. A frame-level reference model turns the
// pixel list of each frame into the list of pooled windows (plain max / floor
// of the mean over four pixels); a compare process checks every presented
// output against it and watches the handshake, done and busy rules.
// ---------------------------------------------------------------------------
module tb_pool2x2_stream;

    localparam int DW    = 16;
    localparam int LANES = 2;
    localparam int MAX_W = 1024;
    localparam int CW    = $clog2(MAX_W + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start;
    logic [CW-1:0]       cfg_width;
    logic [CW-1:0]       cfg_height;
    logic                cfg_mode;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*DW-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [LANES*DW-1:0] out_data;
    logic                busy;
    logic                done;

    int errors = 0;
    int checks = 0;

    int pix0[$];
    int pix1[$];
    int expQ0[$];
    int expQ1[$];
    int recv0[$];
    int recv1[$];

    int doneCnt   = 0;
    bit prevDone  = 1'b0;
    bit hsSeen    = 1'b0;
    bit bpEnable  = 1'b0;
    int stallCnt  = 0;

    always #5 clk = ~clk;

    pool2x2_stream #(
        .DW    (DW),
        .LANES (LANES),
        .MAX_W (MAX_W),
        .CW    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_mode   (cfg_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [LANES*DW-1:0] packBeat(input int l0, input int l1);
        logic [31:0] a;
        logic [31:0] b;
        a = l0;
        b = l1;
        return {b[DW-1:0], a[DW-1:0]};
    endfunction

    function automatic int laneOf(input logic [LANES*DW-1:0] d, input int k);
        logic signed [DW-1:0] v;
        v = d[k*DW +: DW];
        return int'(v);
    endfunction

    function automatic int recvAt(input int lane, input int idx);
        if (idx >= recv0.size()) return -999999;
        return (lane == 0) ? recv0[idx] : recv1[idx];
    endfunction

    function automatic int expAt(input int lane, input int idx);
        if (idx >= expQ0.size()) return -999999;
        return (lane == 0) ? expQ0[idx] : expQ1[idx];
    endfunction

    // Reference model: one output per complete 2x2 window, raster order.
    function automatic int poolWin(input int a, input int b, input int c,
                                   input int d, input bit mode);
        int m;
        if (mode) return (a + b + c + d) >>> 2;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic buildModel(input int w, input int h, input bit mode);
        int base;
        expQ0.delete();
        expQ1.delete();
        recv0.delete();
        recv1.delete();
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                base = (2 * r) * w + 2 * c;
                expQ0.push_back(poolWin(pix0[base], pix0[base+1],
                                        pix0[base+w], pix0[base+w+1], mode));
                expQ1.push_back(poolWin(pix1[base], pix1[base+1],
                                        pix1[base+w], pix1[base+w+1], mode));
            end
        end
    endtask

    // Output side: compare every presented beat against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (expQ0.size() == 0) begin
                    checkVal("spurious out_valid", int'(out_valid), 0);
                end else begin
                    checkVal("out lane0", laneOf(out_data, 0), expQ0[0]);
                    checkVal("out lane1", laneOf(out_data, 1), expQ1[0]);
                    if (out_ready) begin
                        recv0.push_back(laneOf(out_data, 0));
                        recv1.push_back(laneOf(out_data, 1));
                        void'(expQ0.pop_front());
                        void'(expQ1.pop_front());
                        hsSeen = 1'b1;
                    end
                end
                if (!out_ready) begin
                    checkVal("in_ready while stalled", int'(in_ready), 0);
                end
            end
            if (done) begin
                doneCnt++;
                checkVal("done single cycle", int'(prevDone), 0);
                checkVal("busy low at done", int'(busy), 0);
            end
            prevDone = done;
        end else begin
            prevDone = 1'b0;
        end
    end

    // Downstream ready: tied high, or held low 5 cycles on each output.
    always @(posedge clk) begin
        #1;
        if (hsSeen) begin
            stallCnt = 0;
            hsSeen   = 1'b0;
        end
        if (!bpEnable) begin
            out_ready = 1'b1;
        end else if (out_valid) begin
            if (stallCnt < 5) begin
                out_ready = 1'b0;
                stallCnt++;
            end else begin
                out_ready = 1'b1;
            end
        end else begin
            out_ready = 1'b0;
        end
    end

    // Called and returns at posedge+1; holds the beat until accepted.
    task automatic sendBeat(input logic [LANES*DW-1:0] d);
        bit acc;
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) checkVal("input beat accepted in time", int'(acc), 1);
    endtask

    task automatic pulseStart(input int w, input int h, input bit mode);
        @(posedge clk);
        #1;
        start      = 1'b1;
        cfg_width  = CW'(w);
        cfg_height = CW'(h);
        cfg_mode   = mode;
        @(posedge clk);
        #1;
        start      = 1'b0;
        // Scramble cfg; the frame in flight must not notice.
        cfg_width  = CW'(2);
        cfg_height = CW'(2);
        cfg_mode   = ~mode;
    endtask

    task automatic applyStimulus(input int w, input int h, input bit mode,
                                 input bit glitch);
        int n;
        pulseStart(w, h, mode);
        checkVal("busy after start", int'(busy), 1);
        for (int i = 0; i < w * h; i++) begin
            if (glitch && i == 5) start = 1'b1;
            sendBeat(packBeat(pix0[i], pix1[i]));
            start = 1'b0;
        end
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        checkVal("done reached in time", int'(done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int expOut,
                               input int doneBefore);
        checkVal({tag, " output count"}, recv0.size(), expOut);
        checkVal({tag, " model drained"}, expQ0.size(), 0);
        checkVal({tag, " done pulses"}, doneCnt - doneBefore, 1);
        checkVal({tag, " busy idle"}, int'(busy), 0);
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, " in_ready"}, int'(in_ready), 0);
        checkVal({tag, " out_valid"}, int'(out_valid), 0);
        checkVal({tag, " out_data"}, int'(out_data), 0);
        checkVal({tag, " busy"}, int'(busy), 0);
        checkVal({tag, " done"}, int'(done), 0);
    endtask

    initial begin
        int d0;
        start      = 1'b0;
        cfg_width  = '0;
        cfg_height = '0;
        cfg_mode   = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;

        // Max pool 4x2, lanes {p,-p}.
        pix0.delete(); pix1.delete();
        for (int p = 1; p <= 8; p++) begin
            pix0.push_back(p);
            pix1.push_back(-p);
        end
        buildModel(4, 2, 1'b0);
        checkVal("model t1 w0 l0", expAt(0, 0), 6);
        checkVal("model t1 w0 l1", expAt(1, 0), -1);
        checkVal("model t1 w1 l0", expAt(0, 1), 8);
        checkVal("model t1 w1 l1", expAt(1, 1), -3);
        d0 = doneCnt;
        applyStimulus(4, 2, 1'b0, 1'b0);
        checkOutput("max4x2", 2, d0);
        checkVal("max4x2 out0 l0", recvAt(0, 0), 6);
        checkVal("max4x2 out0 l1", recvAt(1, 0), -1);
        checkVal("max4x2 out1 l0", recvAt(0, 1), 8);
        checkVal("max4x2 out1 l1", recvAt(1, 1), -3);

        // Average 2x2 with floor rounding.
        pix0 = '{1, 2, 3, 5};
        pix1 = '{-1, -1, -1, -2};
        buildModel(2, 2, 1'b1);
        checkVal("model avg l0", expAt(0, 0), 2);
        checkVal("model avg l1", expAt(1, 0), -2);
        d0 = doneCnt;
        applyStimulus(2, 2, 1'b1, 1'b0);
        checkOutput("avg2x2", 1, d0);
        checkVal("avg2x2 l0", recvAt(0, 0), 2);
        checkVal("avg2x2 l1", recvAt(1, 0), -2);

        // Backpressure 4x4 max, with an ignored start pulse mid-frame.
        pix0.delete(); pix1.delete();
        for (int p = 0; p < 16; p++) begin
            pix0.push_back(p * 3 - 20);
            pix1.push_back(((p * 7) % 11) - 5);
        end
        buildModel(4, 4, 1'b0);
        checkVal("model bp w3 l0", expAt(0, 3), 25);
        bpEnable = 1'b1;
        d0 = doneCnt;
        applyStimulus(4, 4, 1'b0, 1'b1);
        bpEnable = 1'b0;
        checkOutput("bp4x4", 4, d0);

        // Odd dimensions 5x3, average mode.
        pix0.delete(); pix1.delete();
        for (int p = 1; p <= 15; p++) begin
            pix0.push_back(p);
            pix1.push_back(-p);
        end
        buildModel(5, 3, 1'b1);
        checkVal("model odd w0 l0", expAt(0, 0), 4);
        checkVal("model odd w1 l1", expAt(1, 1), -6);
        d0 = doneCnt;
        applyStimulus(5, 3, 1'b1, 1'b0);
        checkOutput("odd5x3", 2, d0);
        checkVal("odd5x3 out0 l0", recvAt(0, 0), 4);
        checkVal("odd5x3 out1 l0", recvAt(0, 1), 6);
        checkVal("odd5x3 out1 l1", recvAt(1, 1), -6);

        // Extremes.
        pix0 = '{-32768, -32768, -32768, -32768};
        pix1 = '{-32768, -32768, -32768, -32768};
        buildModel(2, 2, 1'b0);
        d0 = doneCnt;
        applyStimulus(2, 2, 1'b0, 1'b0);
        checkOutput("minmax", 1, d0);
        checkVal("minmax l0", recvAt(0, 0), -32768);
        checkVal("minmax l1", recvAt(1, 0), -32768);

        pix0 = '{32767, 32767, 32767, 32767};
        pix1 = '{32767, 32767, 32767, 32767};
        buildModel(2, 2, 1'b1);
        d0 = doneCnt;
        applyStimulus(2, 2, 1'b1, 1'b0);
        checkOutput("maxavg", 1, d0);
        checkVal("maxavg l0", recvAt(0, 0), 32767);
        checkVal("maxavg l1", recvAt(1, 0), 32767);

        // Reset mid-frame after 3 beats, then a clean 2x2 average frame.
        pix0 = '{900, 900, 900, 900, 900, 900, 900, 900};
        pix1 = '{-900, -900, -900, -900, -900, -900, -900, -900};
        expQ0.delete(); expQ1.delete();
        pulseStart(4, 2, 1'b1);
        for (int i = 0; i < 3; i++) sendBeat(packBeat(pix0[i], pix1[i]));
        in_valid = 1'b0;
        d0 = doneCnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkResetState("midreset");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkVal("no done after abort", doneCnt - d0, 0);

        pix0 = '{10, -4, 7, 1};
        pix1 = '{-9, -9, 20, 3};
        buildModel(2, 2, 1'b1);
        checkVal("model rst l0", expAt(0, 0), 3);
        checkVal("model rst l1", expAt(1, 0), 1);
        d0 = doneCnt;
        applyStimulus(2, 2, 1'b1, 1'b0);
        checkOutput("afterreset", 1, d0);
        checkVal("afterreset l0", recvAt(0, 0), 3);
        checkVal("afterreset l1", recvAt(1, 0), 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
